// File: rtl/var_delay_ctrl.sv
// Runtime-programmable delay line: ring buffer of MAX_LENGTH samples replayed L enabled
// cycles later, with a FILL/RUN/FLUSH sequencer and a req/ack reconfiguration handshake.
module var_delay_ctrl #(
  parameter int MAX_LENGTH  = 256,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_LEN = 10,
  parameter int LEN_W       = $clog2(MAX_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             busy
);
  localparam int PTR_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0] DEF_L    = LEN_W'(DEFAULT_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_LENGTH - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [MAX_LENGTH];

  logic             mem_we;
  logic [PTR_W-1:0] back, rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [LEN_W-1:0] fill_inc, clamped;

  // Read address is wr_ptr-(L-1) mod MAX_LENGTH; L=1 reads the sample being written, so bypass.
  always_comb begin
    back     = PTR_W'(len_q - LEN_W'(1));
    rd_addr  = (wr_ptr_q >= back) ? wr_ptr_q - back : wr_ptr_q + (PTR_LAST - back) + PTR_W'(1);
    rd_data  = (len_q == LEN_W'(1)) ? in : mem_q[rd_addr];
    fill_inc = fill_q + LEN_W'(1);
    clamped  = (cfg_len == '0) ? LEN_W'(1) : (cfg_len > MAX_L) ? MAX_L : cfg_len;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cfg_ack_d   = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_FLUSH: state_d = S_FILL;
      default: begin
        if (cfg_req) begin
          // Reconfiguration wins over a coincident sample, which is dropped.
          len_d       = clamped;
          state_d     = S_FLUSH;
          cfg_ack_d   = 1'b1;
          fill_d      = '0;
          out_d       = '0;
          out_valid_d = 1'b0;
        end else if (ena) begin
          mem_we   = 1'b1;
          wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
          if (state_q == S_FILL) begin
            fill_d = fill_inc;
            if (fill_inc >= len_q) begin
              state_d     = S_RUN;
              out_d       = rd_data;
              out_valid_d = 1'b1;
            end else begin
              out_d       = '0;
              out_valid_d = 1'b0;
            end
          end else begin
            out_d       = rd_data;
            out_valid_d = 1'b1;
          end
        end
      end
    endcase
    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      len_q       <= DEF_L;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_ack_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cfg_ack_q   <= cfg_ack_d;
      busy_q      <= busy_d;
    end
  end

  // Buffer contents are never cleared; the fill count alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_ptr_q] <= in;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cfg_ack   = cfg_ack_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_var_delay_ctrl.sv
// Scoreboard bench for var_delay_ctrl: the driver predicts each cycle's outputs from a
// queue-of-accepted-samples model; a monitor pops and compares after every edge.
module tb_var_delay_ctrl;
  localparam int MAX_LENGTH  = 256;
  localparam int WIDTH       = 8;
  localparam int DEFAULT_LEN = 10;
  localparam int LEN_W       = $clog2(MAX_LENGTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             ack;
    logic             busy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1, ena = 1'b0, cfg_req = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [WIDTH-1:0] out;
  logic             out_valid, cfg_ack, busy;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;

  int               m_len = DEFAULT_LEN;
  bit               m_flush = 1'b0;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_hist[$];
  exp_t             m_last = '0;

  always #5 clk = ~clk;

  var_delay_ctrl #(.MAX_LENGTH(MAX_LENGTH), .WIDTH(WIDTH), .DEFAULT_LEN(DEFAULT_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in), .out(out), .out_valid(out_valid),
    .cfg_len(cfg_len), .cfg_req(cfg_req), .cfg_ack(cfg_ack), .busy(busy)
  );

  function automatic int clamp(int v);
    if (v == 0) return 1;
    if (v > MAX_LENGTH) return MAX_LENGTH;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs and predict the outputs after the coming edge.
  task automatic step(bit r, bit e, logic [WIDTH-1:0] d, bit q, int len);
    exp_t x;
    @(negedge clk);
    rst = r; ena = e; in = d; cfg_req = q; cfg_len = LEN_W'(len);
    x = m_last;
    x.ack = 1'b0;
    if (r) begin
      m_len = DEFAULT_LEN; m_flush = 1'b0; m_cnt = 0; m_hist.delete();
      x = '0; x.busy = 1'b1;
    end else if (m_flush) begin
      m_flush = 1'b0;
      x = '0; x.busy = 1'b1;
    end else if (q) begin
      m_len = clamp(len); m_flush = 1'b1; m_cnt = 0; m_hist.delete();
      x = '0; x.ack = 1'b1; x.busy = 1'b1;
    end else if (e) begin
      m_cnt++;
      m_hist.push_back(d);
      if (m_hist.size() > MAX_LENGTH) void'(m_hist.pop_front());
      if (m_cnt >= m_len) begin
        x.out = m_hist[m_hist.size() - m_len]; x.valid = 1'b1; x.busy = 1'b0;
      end else begin
        x.out = '0; x.valid = 1'b0; x.busy = 1'b1;
      end
    end
    m_last = x;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(x.valid));
      chk("out", 32'(out), 32'(x.out));
      chk("cfg_ack", 32'(cfg_ack), 32'(x.ack));
      chk("busy", 32'(busy), 32'(x.busy));
    end
  end

  initial begin
    int v;
    v = 1;
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'hAA, 1, 3);
    // Default length ramp into RUN
    for (int i = 0; i < 20; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    // Reconfigure to 3, colliding with an enabled sample
    step(0, 1, WIDTH'(v), 1, 3); v++;
    for (int i = 0; i < 10; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    // Clamp low: L=1
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    // Clamp high: L=MAX_LENGTH, ramp long enough to wrap the buffer
    step(0, 1, 0, 1, MAX_LENGTH + 5);
    for (int i = 0; i < 300; i++) begin step(0, 1, WIDTH'(i), 0, 0); end
    // Held request: two acks
    step(0, 1, 1, 1, 4);
    step(0, 1, 2, 1, 5);
    step(0, 1, 3, 1, 6);
    for (int i = 0; i < 10; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    // Random ena gating with sporadic reconfiguration
    for (int i = 0; i < 700; i++) begin
      int l;
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       l = 0;
          1:       l = MAX_LENGTH + int'($urandom_range(1, 100));
          default: l = int'($urandom_range(1, 16));
        endcase
        step(0, 1'($urandom_range(0, 1)), d, 1, l);
      end else begin
        step(0, 1'($urandom_range(0, 1)), d, 0, int'($urandom_range(0, 300)));
      end
    end
    // Reset during FLUSH, then reset mid-FILL
    step(0, 1, 7, 1, 2);
    step(1, 1, 8, 1, 2);
    step(0, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin step(0, 1, WIDTH'(v), 0, 0); v++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
